// File: rtl/button_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the button conditioning blocks: FSM state encoding and width helper.
package button_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_PEND   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_PEND = 2'd3
    } state_e;

    // Bits needed to hold values 0 .. value-1; never returns less than 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned     width;
        longint unsigned span;
        width = 0;
        span  = 1;
        while (span < 64'(value)) begin
            span  = span << 1;
            width = width + 1;
        end
        return (width == 0) ? 1 : width;
    endfunction

endpackage : button_pkg

// File: rtl/btn_synchronizer.sv
`timescale 1ns/1ps
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
module btn_synchronizer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b1
) (
    input  logic clk,
    input  logic rst_btn,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule : btn_synchronizer

// File: rtl/button_conditioner.sv
`timescale 1ns/1ps
// Debounces an active-low push-button into a clean level plus press, release and
// long-press pulses. "release" is a reserved word, hence the release_o port name.
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned DEBOUNCE_COUNT = 250000,
    parameter int unsigned LONG_COUNT     = 50000000
) (
    input  logic clk,
    input  logic rst_btn,
    input  logic btn_in,
    output logic level,
    output logic press,
    output logic release_o,
    output logic long_press
);

    localparam int unsigned        CNT_W    = clog2(LONG_COUNT + 1);
    localparam logic [CNT_W-1:0]   DEB_LAST = CNT_W'(DEBOUNCE_COUNT - 1);
    localparam logic [CNT_W-1:0]   LNG_LAST = CNT_W'(LONG_COUNT - 1);
    localparam logic [CNT_W-1:0]   LNG_MAX  = CNT_W'(LONG_COUNT);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    logic             btn_sync;
    logic             pressed_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic             press_evt_q, press_evt_d;
    logic             release_evt_q, release_evt_d;
    logic             long_evt_q, long_evt_d;

    btn_synchronizer #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sync (
        .clk     (clk),
        .rst_btn (rst_btn),
        .d       (btn_in),
        .q       (btn_sync)
    );

    assign pressed_s = ~btn_sync;

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            state_q       <= ST_RELEASED;
            cnt_q         <= '0;
            armed_q       <= 1'b0;
            press_evt_q   <= 1'b0;
            release_evt_q <= 1'b0;
            long_evt_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            armed_q       <= armed_d;
            press_evt_q   <= press_evt_d;
            release_evt_q <= release_evt_d;
            long_evt_q    <= long_evt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        armed_d       = armed_q;
        press_evt_d   = 1'b0;
        release_evt_d = 1'b0;
        long_evt_d    = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (pressed_s) begin
                    state_d = ST_PRESS_PEND;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_PRESS_PEND: begin
                if (!pressed_s) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d     = ST_PRESSED;
                    cnt_d       = '0;
                    press_evt_d = 1'b1;
                    armed_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                // Single long-press per press: the armed flag is consumed on fire.
                if (armed_q && (cnt_q == LNG_LAST)) begin
                    long_evt_d = 1'b1;
                    armed_d    = 1'b0;
                end
                if (!pressed_s) begin
                    state_d = ST_RELEASE_PEND;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q != LNG_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RELEASE_PEND: begin
                if (pressed_s) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d       = ST_RELEASED;
                    cnt_d         = '0;
                    release_evt_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    // Output stage: every output is a flop fed from the registered FSM view.
    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            level      <= 1'b0;
            press      <= 1'b0;
            release_o  <= 1'b0;
            long_press <= 1'b0;
        end else begin
            level      <= (state_q == ST_PRESSED) || (state_q == ST_RELEASE_PEND);
            press      <= press_evt_q;
            release_o  <= release_evt_q;
            long_press <= long_evt_q;
        end
    end

endmodule : button_conditioner
